// File: rtl/wb_port_arbiter_if.sv
// Bus bundle for wb_port_arbiter: core write/read requests, load issue and
// response handshakes, register-file write port and status outputs.
// master = requester/environment side, slave = the arbiter.
interface wb_port_arbiter_if #(
  parameter int unsigned DATA_W = 8
);
  // Core datapath requests
  logic              core_wr_en;
  logic [3:0]        core_wr_reg;
  logic [DATA_W-1:0] core_wr_data;
  logic              core_rd_en_a;
  logic              core_rd_en_b;
  logic [3:0]        core_rd_reg_a;
  logic [3:0]        core_rd_reg_b;

  // Load issue / return path
  logic              ld_issue;
  logic [3:0]        ld_issue_reg;
  logic              ld_issue_ready;
  logic              ld_rsp_valid;
  logic [DATA_W-1:0] ld_rsp_data;
  logic              ld_rsp_ready;

  // Register-file write port and status
  logic              rf_wr_en;
  logic [3:0]        rf_wr_reg;
  logic [DATA_W-1:0] rf_wr_data;
  logic              stall;
  logic [15:0]       pending_mask;
  logic              err;
  logic [15:0]       stall_count;

  modport master (
    output core_wr_en, core_wr_reg, core_wr_data,
    output core_rd_en_a, core_rd_en_b, core_rd_reg_a, core_rd_reg_b,
    output ld_issue, ld_issue_reg, ld_rsp_valid, ld_rsp_data,
    input  ld_issue_ready, ld_rsp_ready,
    input  rf_wr_en, rf_wr_reg, rf_wr_data,
    input  stall, pending_mask, err, stall_count
  );

  modport slave (
    input  core_wr_en, core_wr_reg, core_wr_data,
    input  core_rd_en_a, core_rd_en_b, core_rd_reg_a, core_rd_reg_b,
    input  ld_issue, ld_issue_reg, ld_rsp_valid, ld_rsp_data,
    output ld_issue_ready, ld_rsp_ready,
    output rf_wr_en, rf_wr_reg, rf_wr_data,
    output stall, pending_mask, err, stall_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the core
// datapath (priority) and the in-order load-return path. Keeps a scoreboard of
// registers with outstanding loads and stalls the core on RAW/WAW hazards.
// Optional macro WB_STALL_CNT_EN builds a saturating stall-cycle counter;
// without it stall_count is tied to zero.
// QDEPTH must be a power of two, at least 2.
module wb_port_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned QDEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  wb_port_arbiter_if.slave   bus
);

  localparam int unsigned PtrW = $clog2(QDEPTH);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e            state_q, state_d;
  logic [15:0]       pending_q, pending_d;
  logic              err_q, err_d;
  logic              rf_wr_en_q, rf_wr_en_d;
  logic [3:0]        rf_wr_reg_q, rf_wr_reg_d;
  logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;
  logic [3:0]        hold_reg_q, hold_reg_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;

  // Pending-destination FIFO; pointers carry an extra wrap bit.
  logic [3:0]        fifo_q [QDEPTH];
  logic [PtrW:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]     rd_ptr_q, rd_ptr_d;
  logic              fifo_empty, fifo_full;
  logic [3:0]        fifo_head;

  logic              issue_ok, push, pop;
  logic              stall, core_go;
  logic              rsp_err;
  logic              clr_en;
  logic [3:0]        clr_idx;
  logic [15:0]       set_vec, clr_vec;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign fifo_head  = fifo_q[rd_ptr_q[PtrW-1:0]];

  // A register with a load in flight cannot take a second issue.
  assign issue_ok = !fifo_full && !pending_q[bus.ld_issue_reg];
  assign push     = bus.ld_issue && issue_ok;

  assign stall = (bus.core_rd_en_a && pending_q[bus.core_rd_reg_a]) ||
                 (bus.core_rd_en_b && pending_q[bus.core_rd_reg_b]) ||
                 (bus.core_wr_en   && pending_q[bus.core_wr_reg]);
  assign core_go = bus.core_wr_en && !stall;

  // Write-port arbitration and hold-slot management.
  always_comb begin
    state_d      = state_q;
    rf_wr_en_d   = 1'b0;
    rf_wr_reg_d  = rf_wr_reg_q;
    rf_wr_data_d = rf_wr_data_q;
    hold_reg_d   = hold_reg_q;
    hold_data_d  = hold_data_q;
    pop          = 1'b0;
    clr_en       = 1'b0;
    clr_idx      = 4'd0;
    rsp_err      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A response with nothing outstanding is consumed and dropped.
        if (bus.ld_rsp_valid && fifo_empty) begin
          rsp_err = 1'b1;
        end
        if (core_go) begin
          rf_wr_en_d   = 1'b1;
          rf_wr_reg_d  = bus.core_wr_reg;
          rf_wr_data_d = bus.core_wr_data;
          if (bus.ld_rsp_valid && !fifo_empty) begin
            // Park the load; its pending bit stays set until it is written.
            hold_reg_d  = fifo_head;
            hold_data_d = bus.ld_rsp_data;
            pop         = 1'b1;
            state_d     = StHold;
          end
        end else if (bus.ld_rsp_valid && !fifo_empty) begin
          rf_wr_en_d   = 1'b1;
          rf_wr_reg_d  = fifo_head;
          rf_wr_data_d = bus.ld_rsp_data;
          pop          = 1'b1;
          clr_en       = 1'b1;
          clr_idx      = fifo_head;
        end
      end
      StHold: begin
        if (core_go) begin
          rf_wr_en_d   = 1'b1;
          rf_wr_reg_d  = bus.core_wr_reg;
          rf_wr_data_d = bus.core_wr_data;
        end else begin
          rf_wr_en_d   = 1'b1;
          rf_wr_reg_d  = hold_reg_q;
          rf_wr_data_d = hold_data_q;
          clr_en       = 1'b1;
          clr_idx      = hold_reg_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Scoreboard, FIFO pointer and error next-state.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (push) begin
      set_vec[bus.ld_issue_reg] = 1'b1;
    end
    if (clr_en) begin
      clr_vec[clr_idx] = 1'b1;
    end
    // Set and clear never target the same register: issue requires the bit clear.
    pending_d = (pending_q | set_vec) & ~clr_vec;
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    err_d     = err_q | (bus.ld_issue && !issue_ok) | rsp_err;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      err_q        <= 1'b0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_reg_q  <= '0;
      rf_wr_data_q <= '0;
      hold_reg_q   <= '0;
      hold_data_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      err_q        <= err_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_reg_q  <= rf_wr_reg_d;
      rf_wr_data_q <= rf_wr_data_d;
      hold_reg_q   <= hold_reg_d;
      hold_data_q  <= hold_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_q[wr_ptr_q[PtrW-1:0]] <= bus.ld_issue_reg;
    end
  end

`ifdef WB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_count = stall_cnt_q;
`else
  assign bus.stall_count = 16'd0;
`endif

  assign bus.ld_issue_ready = issue_ok;
  assign bus.ld_rsp_ready   = (state_q == StIdle);
  assign bus.rf_wr_en       = rf_wr_en_q;
  assign bus.rf_wr_reg      = rf_wr_reg_q;
  assign bus.rf_wr_data     = rf_wr_data_q;
  assign bus.stall          = stall;
  assign bus.pending_mask   = pending_q;
  assign bus.err            = err_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter.
module tb_wb_port_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  wb_port_arbiter_if #(.DATA_W(8)) bus ();

  wb_port_arbiter #(
    .DATA_W(8),
    .QDEPTH(2)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.core_wr_en    = 1'b0;
    bus.core_wr_reg   = 4'd0;
    bus.core_wr_data  = 8'd0;
    bus.core_rd_en_a  = 1'b0;
    bus.core_rd_en_b  = 1'b0;
    bus.core_rd_reg_a = 4'd0;
    bus.core_rd_reg_b = 4'd0;
    bus.ld_issue      = 1'b0;
    bus.ld_issue_reg  = 4'd0;
    bus.ld_rsp_valid  = 1'b0;
    bus.ld_rsp_data   = 8'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_cnt;
    total = 0;
    bad   = 0;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_wr_en", 32'(bus.rf_wr_en), 32'h0);
    check("rst_wr_reg", 32'(bus.rf_wr_reg), 32'h0);
    check("rst_wr_data", 32'(bus.rf_wr_data), 32'h0);
    check("rst_pending", 32'(bus.pending_mask), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    check("rst_stall_cnt", 32'(bus.stall_count), 32'h0);
    check("rst_issue_rdy", 32'(bus.ld_issue_ready), 32'h1);
    check("rst_rsp_rdy", 32'(bus.ld_rsp_ready), 32'h1);

    // Core-only write
    bus.core_wr_en = 1'b1; bus.core_wr_reg = 4'hf; bus.core_wr_data = 8'h5A;
    #1 check("core_stall", 32'(bus.stall), 32'h0);
    tick();
    idle_inputs();
    check("core_wr_en", 32'(bus.rf_wr_en), 32'h1);
    check("core_wr_reg", 32'(bus.rf_wr_reg), 32'hf);
    check("core_wr_data", 32'(bus.rf_wr_data), 32'h5A);
    tick();
    check("core_no_winner", 32'(bus.rf_wr_en), 32'h0);

    // RAW stall on r7, cleared when the load data is written
    bus.ld_issue = 1'b1; bus.ld_issue_reg = 4'd7;
    #1 check("raw_issue_rdy", 32'(bus.ld_issue_ready), 32'h1);
    tick();
    bus.ld_issue = 1'b0;
    check("raw_pending", 32'(bus.pending_mask), 32'h0080);
    bus.core_rd_en_a = 1'b1; bus.core_rd_reg_a = 4'd7;
    #1 check("raw_stall", 32'(bus.stall), 32'h1);
    bus.ld_rsp_valid = 1'b1; bus.ld_rsp_data = 8'h33;
    tick();
    bus.ld_rsp_valid = 1'b0;
    #1;
    check("raw_wr_en", 32'(bus.rf_wr_en), 32'h1);
    check("raw_wr_reg", 32'(bus.rf_wr_reg), 32'h7);
    check("raw_wr_data", 32'(bus.rf_wr_data), 32'h33);
    check("raw_pending_clr", 32'(bus.pending_mask), 32'h0);
    check("raw_stall_clr", 32'(bus.stall), 32'h0);
    idle_inputs();

    // Collision: load to r13 returns alongside a core write to r15
    bus.ld_issue = 1'b1; bus.ld_issue_reg = 4'd13;
    tick();
    bus.ld_issue = 1'b0;
    bus.ld_rsp_valid = 1'b1; bus.ld_rsp_data = 8'hAA;
    bus.core_wr_en = 1'b1; bus.core_wr_reg = 4'hf; bus.core_wr_data = 8'h01;
    #1 check("col_stall", 32'(bus.stall), 32'h0);
    tick();
    idle_inputs();
    check("col_core_reg", 32'(bus.rf_wr_reg), 32'hf);
    check("col_core_data", 32'(bus.rf_wr_data), 32'h01);
    check("col_hold_rdy", 32'(bus.ld_rsp_ready), 32'h0);
    check("col_pending", 32'(bus.pending_mask), 32'h2000);
    // A further core write keeps the load parked
    bus.core_wr_en = 1'b1; bus.core_wr_reg = 4'd4; bus.core_wr_data = 8'h44;
    tick();
    idle_inputs();
    check("hold_core_reg", 32'(bus.rf_wr_reg), 32'h4);
    check("hold_core_data", 32'(bus.rf_wr_data), 32'h44);
    check("hold_still_rdy", 32'(bus.ld_rsp_ready), 32'h0);
    tick();
    check("hold_wr_en", 32'(bus.rf_wr_en), 32'h1);
    check("hold_wr_reg", 32'(bus.rf_wr_reg), 32'hd);
    check("hold_wr_data", 32'(bus.rf_wr_data), 32'hAA);
    check("hold_pending_clr", 32'(bus.pending_mask), 32'h0);
    check("hold_rsp_rdy", 32'(bus.ld_rsp_ready), 32'h1);

    // Full and duplicate issue
    bus.ld_issue = 1'b1; bus.ld_issue_reg = 4'd1;
    tick();
    bus.ld_issue_reg = 4'd2;
    #1 check("full_issue2_rdy", 32'(bus.ld_issue_ready), 32'h1);
    tick();
    bus.ld_issue = 1'b0; bus.ld_issue_reg = 4'd3;
    #1 check("full_rdy", 32'(bus.ld_issue_ready), 32'h0);
    bus.ld_rsp_valid = 1'b1; bus.ld_rsp_data = 8'h11;
    tick();
    bus.ld_rsp_valid = 1'b0;
    check("full_pop_reg", 32'(bus.rf_wr_reg), 32'h1);
    check("full_pop_data", 32'(bus.rf_wr_data), 32'h11);
    bus.ld_issue_reg = 4'd2;
    #1 check("dup_rdy", 32'(bus.ld_issue_ready), 32'h0);
    bus.ld_issue_reg = 4'd5;
    #1 check("nondup_rdy", 32'(bus.ld_issue_ready), 32'h1);
    check("dup_err_before", 32'(bus.err), 32'h0);
    bus.ld_issue = 1'b1; bus.ld_issue_reg = 4'd2;
    tick();
    bus.ld_issue = 1'b0;
    check("dup_err", 32'(bus.err), 32'h1);
    check("dup_pending", 32'(bus.pending_mask), 32'h0004);

    // Reset mid-operation: r2 parked in HOLD, r9 outstanding
    bus.ld_issue = 1'b1; bus.ld_issue_reg = 4'd9;
    tick();
    bus.ld_issue = 1'b0;
    bus.ld_rsp_valid = 1'b1; bus.ld_rsp_data = 8'h22;
    bus.core_wr_en = 1'b1; bus.core_wr_reg = 4'hf; bus.core_wr_data = 8'h77;
    tick();
    idle_inputs();
    check("mid_hold", 32'(bus.ld_rsp_ready), 32'h0);
    check("mid_pending", 32'(bus.pending_mask), 32'h0204);
    do_reset();
    bus.ld_issue_reg = 4'd2;
    #1;
    check("mid_rst_pending", 32'(bus.pending_mask), 32'h0);
    check("mid_rst_wr_en", 32'(bus.rf_wr_en), 32'h0);
    check("mid_rst_issue_rdy", 32'(bus.ld_issue_ready), 32'h1);
    check("mid_rst_rsp_rdy", 32'(bus.ld_rsp_ready), 32'h1);
    check("mid_rst_err", 32'(bus.err), 32'h0);
    bus.ld_rsp_valid = 1'b1; bus.ld_rsp_data = 8'h99;
    tick();
    bus.ld_rsp_valid = 1'b0;
    check("orphan_err", 32'(bus.err), 32'h1);
    check("orphan_wr_en", 32'(bus.rf_wr_en), 32'h0);

    // Stall counter: five stalled cycles with a WAW write held off
    idle_inputs();
    do_reset();
    bus.ld_issue = 1'b1; bus.ld_issue_reg = 4'd6;
    tick();
    bus.ld_issue = 1'b0;
    bus.core_rd_en_b = 1'b1; bus.core_rd_reg_b = 4'd6;
    bus.core_wr_en = 1'b1; bus.core_wr_reg = 4'd6; bus.core_wr_data = 8'h66;
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    check("waw_blocked", 32'(bus.rf_wr_en), 32'h0);
    idle_inputs();
`ifdef WB_STALL_CNT_EN
    exp_cnt = 16'd5;
`else
    exp_cnt = 16'd0;
`endif
    #1 check("stall_count", 32'(bus.stall_count), 32'(exp_cnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port and shares it between two requesters.
- Requester 1 is the core datapath write, whose destination is chosen by the write-register decoder: accumulator r15, immediate r7, accumulator reference r14, frame base r13, or an instruction-encoded register.
- Requester 2 is the in-order load-return path from data memory.
- Tracks registers with outstanding loads (scoreboard) and raises stall on read-after-write (RAW) and write-after-write (WAW) hazards against them.

Parameters:
- DATA_W, 8, register data width.
- QDEPTH, 2, max outstanding loads (pending-destination FIFO depth, power of 2).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- core_wr_en  input  1  core requests a register write this cycle.
- core_wr_reg  input  4  core destination register (from the write-register decoder).
- core_wr_data  input  DATA_W  core write data.
- core_rd_en_a / core_rd_en_b  input  1 each  core read-port enables.
- core_rd_reg_a / core_rd_reg_b  input  4 each  core read addresses.
- ld_issue  input  1  load issued to memory.
- ld_issue_reg  input  4  load destination register.
- ld_issue_ready  output  1  load may issue this cycle.
- ld_rsp_valid  input  1  load data returning (in issue order).
- ld_rsp_data  input  DATA_W  load data.
- ld_rsp_ready  output  1  arbiter accepts the load response.
- rf_wr_en  output  1  register-file write enable (registered).
- rf_wr_reg  output  4  register-file write address (registered).
- rf_wr_data  output  DATA_W  register-file write data (registered).
- stall  output  1  core must hold the current instruction.
- pending_mask  output  16  bit n set means a load to rn is outstanding.
- err  output  1  sticky protocol error.
- stall_count  output  16  stall-cycle counter (see Optional Feature).

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - rf_wr_en=0, rf_wr_reg=0, rf_wr_data=0.
  - pending_mask=0, FIFO empty, state=IDLE, err=0, stall_count=0.
  - Any load in flight is abandoned.
- Pending FIFO holds destination register numbers, in issue order.
- ld_issue_ready = !fifo_full && !pending_mask[ld_issue_reg] (combinational).
  - Issuing to an already-pending register is blocked, so each register has at most one load in flight.
- Accepted issue (ld_issue && ld_issue_ready): push ld_issue_reg into the FIFO; set pending_mask[ld_issue_reg] next cycle.
- ld_issue while not ready: ignored, err<=1.
- stall (combinational) is high when any of the following holds:
  - core_rd_en_a && pending_mask[core_rd_reg_a]
  - core_rd_en_b && pending_mask[core_rd_reg_b]
  - core_wr_en && pending_mask[core_wr_reg]
- core_go = core_wr_en && !stall.
- State machine:
  - IDLE, no hold entry:
    - ld_rsp_ready=1.
    - On ld_rsp_valid && !core_go: write the load (rf_wr_reg = FIFO head, data = ld_rsp_data); pop FIFO; clear pending bit.
    - On ld_rsp_valid && core_go: write the core request; latch {head, ld_rsp_data} into the hold register; pop FIFO; go HOLD. The pending bit stays set.
    - On core_go alone: write the core request.
  - HOLD:
    - ld_rsp_ready=0.
    - If !core_go: write the held entry, clear its pending bit, go IDLE.
    - If core_go: the core writes; stay HOLD.
  - Core always has priority. A held load may wait indefinitely while core writes continue back-to-back, but its pending bit keeps stall asserted for any dependent instruction.
- Write latency: the register-file write occurs one cycle after acceptance (outputs registered). rf_wr_en=0 in cycles with no winner.
- Clearing a pending bit takes effect on the same edge as the rf write is registered, so stall deasserts the cycle the data is visible in the register file.
- An issue and a commit to the same register in the same cycle: the issue is blocked (bit still set) and retries next cycle.
- ld_rsp_valid with an empty FIFO: response consumed and dropped, err<=1.
- FIFO wrap-around: the pointers carry one extra bit so full and empty are distinguishable; push and pop in the same cycle keep the count constant.
- err is sticky until reset.

Optional Feature:
- Macro WB_STALL_CNT_EN.
- Defined: stall_count increments each cycle stall=1 and saturates at 16'hFFFF; cleared by reset.
- Undefined: stall_count is tied to 0 and no counter logic is built.

Test Plan:
- Core-only: core_wr_en=1, reg=4'hf, data=8'h5A -> next cycle rf_wr_en=1, rf_wr_reg=f, rf_wr_data=5A; stall=0.
- RAW stall: issue load to r7; cycle after, core reads r7 -> stall=1. Return rsp 8'h33 -> rf write r7=33; pending_mask[7]=0 and stall=0 the cycle the write is registered.
- Collision: load to r13 pending; in one cycle ld_rsp_valid (8'hAA) and core write r15=8'h01 -> cycle N+1 writes r15=01, state HOLD, ld_rsp_ready=0; next idle core cycle writes r13=AA.
- Full/duplicate: issue loads to r1 then r2 with QDEPTH=2 -> ld_issue_ready=0. Issue to r1 while r1 is pending -> ld_issue_ready=0. Forcing ld_issue anyway -> err=1.
- Reset mid-operation: two loads pending plus a HOLD entry; assert reset one cycle -> pending_mask=0, rf_wr_en=0, ld_issue_ready=1. A subsequent orphan ld_rsp_valid -> dropped, err=1.
- With WB_STALL_CNT_EN: hold stall for 5 cycles -> stall_count=5. Without the macro, the same stimulus -> stall_count=0.
